// File: rtl/spi_slave_settings.sv
// rtl/spi_slave_settings.sv - oversampled SPI slave turning 40-bit frames into settings writes and readbacks
module spi_slave_settings #(
   parameter int SYNC_STAGES = 2,
   parameter int AWIDTH      = 7,
   parameter int DWIDTH      = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              spi_cs_n,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic              set_stb,
   output logic [AWIDTH-1:0] set_addr,
   output logic [DWIDTH-1:0] set_data,
   output logic              rb_stb,
   output logic [AWIDTH-1:0] rb_addr,
   input  logic [DWIDTH-1:0] rb_data
);

   localparam int CMD_BITS = AWIDTH + 1;
   localparam int CW       = $clog2(DWIDTH + CMD_BITS + 1);

   typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync, sync_fill;
   logic                   sclk_d, cs_d, cs_armed;
   logic                   sclk_s, mosi_s, cs_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall;

   state_t                 state;
   logic [CW-1:0]          bit_cnt;
   logic [DWIDTH-1:0]      shreg;
   logic [AWIDTH-1:0]      addr_lat;
   logic [1:0]             rd_step;
   logic [CMD_BITS-1:0]    cmd_word;
   logic [DWIDTH-1:0]      shift_in;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;
   assign cmd_word  = {shreg[AWIDTH-1:0], mosi_s};
   assign shift_in  = {shreg[DWIDTH-2:0], mosi_s};
   // Output register is cleared on deselect, so gating with oe keeps miso at 0 outside the data phase
   assign spi_miso  = spi_miso_oe & shreg[DWIDTH-1];

   // Synchronise the SPI pins; cs_n is only trusted (armed) once a real deselect is seen after reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_sync   <= '1;
         sync_fill <= '0;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
         cs_armed  <= 1'b0;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         sync_fill <= {sync_fill[SYNC_STAGES-2:0], 1'b1};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
         if (sync_fill[SYNC_STAGES-1] && cs_s)
            cs_armed <= 1'b1;
      end
   end

   // Frame FSM: command byte, then write-data capture or readback shift-out
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         shreg       <= '0;
         addr_lat    <= '0;
         rd_step     <= 2'd0;
         spi_miso_oe <= 1'b0;
         set_stb     <= 1'b0;
         set_addr    <= '0;
         set_data    <= '0;
         rb_stb      <= 1'b0;
         rb_addr     <= '0;
      end else begin
         set_stb <= 1'b0;
         rb_stb  <= 1'b0;
         if (cs_rise) begin
            // deselect wins over any coincident sclk edge
            state       <= IDLE;
            shreg       <= '0;
            rd_step     <= 2'd0;
            spi_miso_oe <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (cs_fall && cs_armed) begin
                     state   <= CMD;
                     bit_cnt <= '0;
                     shreg   <= '0;
                     rd_step <= 2'd0;
                  end
               end
               CMD: begin
                  if (rd_step == 2'd1) begin
                     // rb_stb is high this cycle; readback data is valid on the next one
                     rd_step <= 2'd2;
                  end else if (rd_step == 2'd2) begin
                     shreg       <= rb_data;
                     spi_miso_oe <= 1'b1;
                     bit_cnt     <= '0;
                     rd_step     <= 2'd0;
                     state       <= RDATA;
                  end else if (sclk_rise) begin
                     shreg <= shift_in;
                     if (bit_cnt == CW'(CMD_BITS - 1)) begin
                        bit_cnt  <= '0;
                        addr_lat <= cmd_word[AWIDTH-1:0];
                        if (cmd_word[AWIDTH]) begin
                           rb_stb  <= 1'b1;
                           rb_addr <= cmd_word[AWIDTH-1:0];
                           rd_step <= 2'd1;
                        end else begin
                           state <= WDATA;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                     end
                  end
               end
               WDATA: begin
                  if (sclk_rise) begin
                     shreg <= shift_in;
                     if (bit_cnt == CW'(DWIDTH - 1)) begin
                        set_stb  <= 1'b1;
                        set_addr <= addr_lat;
                        set_data <= shift_in;
                        state    <= DONE;
                     end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                     end
                  end
               end
               RDATA: begin
                  if (sclk_rise) begin
                     if (bit_cnt == CW'(DWIDTH - 1))
                        state <= DONE;
                     else
                        bit_cnt <= bit_cnt + CW'(1);
                  end else if (sclk_fall && bit_cnt != '0) begin
                     // the fall that follows the command byte must not shift away the MSB
                     shreg <= {shreg[DWIDTH-2:0], 1'b0};
                  end
               end
               DONE: begin
                  state <= DONE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
